// File: rtl/cpu_pkg.sv
// Types and constants shared by the fetch unit and the branch controller:
// fetch state encoding, control-flow opcodes and default datapath widths.
package cpu_pkg;

  localparam int CPU_DWIDTH = 32;
  localparam int CPU_AWIDTH = 15;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_OUT  = 2'd2
  } fetch_state_e;

  // Control-flow opcodes decoded by the branch controller
  localparam logic [3:0] OP_JR   = 4'h8;
  localparam logic [3:0] OP_JPC  = 4'h9;
  localparam logic [3:0] OP_BRFL = 4'hA;
  localparam logic [3:0] OP_CALL = 4'hB;
  localparam logic [3:0] OP_RET  = 4'hC;

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating event counter used for fetch statistics (built only with FETCH_PERF_EN).
module fetch_perf_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC holder and instruction fetch sequencer with redirect/discard handling.
// Optional statistics outputs (perf_fetched, perf_discarded) under FETCH_PERF_EN.
//   state      | meaning
//   FETCH_IDLE | one cycle after reset, latches first fetch address
//   FETCH_REQ  | imem_req high at req_addr, waiting for imem_ack
//   FETCH_OUT  | instruction held on instr_out until decode accepts
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                DWIDTH   = CPU_DWIDTH,
  parameter int                AWIDTH   = CPU_AWIDTH,
  parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [DWIDTH-1:0] redirect_target,
  output logic              imem_req,
  output logic [AWIDTH-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DWIDTH-1:0] imem_rdata,
  output logic [DWIDTH-1:0] instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [AWIDTH-1:0] instr_pc,
  output logic [AWIDTH-1:0] link_addr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_discarded
`endif
);

  fetch_state_e      state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [AWIDTH-1:0] req_addr_q, req_addr_d;
  logic              discard_q, discard_d;
  logic [DWIDTH-1:0] instr_out_q, instr_out_d;
  logic [AWIDTH-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic              evt_fetched, evt_discard;
  logic [AWIDTH-1:0] target;
  logic              unused_target_hi;

  // Targets beyond the address space are truncated, upper bits ignored
  assign target           = redirect_target[AWIDTH-1:0];
  assign unused_target_hi = ^redirect_target[DWIDTH-1:AWIDTH];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    discard_d     = discard_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    evt_fetched   = 1'b0;
    evt_discard   = 1'b0;

    if (redirect_valid) pc_d = target;

    case (state_q)
      FETCH_IDLE: begin
        req_addr_d = redirect_valid ? target : pc_q;
        state_d    = FETCH_REQ;
      end
      FETCH_REQ: begin
        if (imem_ack) begin
          if (discard_q || redirect_valid) begin
            discard_d   = 1'b0;
            req_addr_d  = redirect_valid ? target : pc_q;
            evt_discard = 1'b1;
          end else begin
            instr_out_d   = imem_rdata;
            instr_pc_d    = req_addr_q;
            instr_valid_d = 1'b1;
            pc_d          = req_addr_q + AWIDTH'(1);
            state_d       = FETCH_OUT;
          end
        end else if (redirect_valid) begin
          // Address must stay stable until the outstanding read completes
          discard_d = 1'b1;
        end
      end
      FETCH_OUT: begin
        if (redirect_valid) begin
          instr_valid_d = 1'b0;
          req_addr_d    = target;
          state_d       = FETCH_REQ;
          evt_discard   = 1'b1;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          req_addr_d    = pc_q;
          state_d       = FETCH_REQ;
          evt_fetched   = 1'b1;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FETCH_IDLE;
      pc_q          <= RESET_PC;
      req_addr_q    <= RESET_PC;
      discard_q     <= 1'b0;
      instr_out_q   <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      discard_q     <= discard_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req    = (state_q == FETCH_REQ);
  assign imem_addr   = req_addr_q;
  assign instr_out   = instr_out_q;
  assign instr_valid = instr_valid_q;
  assign instr_pc    = instr_pc_q;
  assign link_addr   = instr_pc_q + AWIDTH'(1);

`ifdef FETCH_PERF_EN
  fetch_perf_counter #(.WIDTH(32)) u_perf_fetched (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (evt_fetched),
    .count_o(perf_fetched)
  );

  fetch_perf_counter #(.WIDTH(32)) u_perf_discarded (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (evt_discard),
    .count_o(perf_discarded)
  );
`else
  logic unused_perf;
  assign unused_perf = evt_fetched ^ evt_discard;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed stimulus pushes expected fetches,
// a negedge monitor pops them on each decode handshake.
module tb_pc_fetch_unit;

  typedef struct {
    logic [14:0] pc;
    logic [14:0] link;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [14:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic [14:0] instr_pc;
  logic [14:0] link_addr;

  logic        w_imem_req;
  logic [14:0] w_imem_addr;
  logic        w_imem_ack;
  logic [31:0] w_imem_rdata;
  logic [31:0] w_instr_out;
  logic        w_instr_valid;
  logic        w_instr_ready;
  logic [14:0] w_instr_pc;
  logic [14:0] w_link_addr;
  logic        w_done;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_discarded;
  logic [31:0] w_perf_fetched, w_perf_discarded;
`endif

  int   n_checks = 0;
  int   n_pass   = 0;
  int   popped   = 0;
  int   lat      = 1;
  int   cnt      = 0;
  int   w_cnt    = 0;
  exp_t exp_q[$];

  pc_fetch_unit #(.DWIDTH(32), .AWIDTH(15), .RESET_PC(15'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_out      (instr_out),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_pc       (instr_pc),
    .link_addr      (link_addr)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_discarded (perf_discarded)
`endif
  );

  pc_fetch_unit #(.DWIDTH(32), .AWIDTH(15), .RESET_PC(15'h7FFF)) dut_w (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (1'b0),
    .redirect_target(32'h0),
    .imem_req       (w_imem_req),
    .imem_addr      (w_imem_addr),
    .imem_ack       (w_imem_ack),
    .imem_rdata     (w_imem_rdata),
    .instr_out      (w_instr_out),
    .instr_valid    (w_instr_valid),
    .instr_ready    (w_instr_ready),
    .instr_pc       (w_instr_pc),
    .link_addr      (w_link_addr)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (w_perf_fetched),
    .perf_discarded (w_perf_discarded)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic [14:0] pc, input logic [14:0] link);
    exp_t e;
    e.pc   = pc;
    e.link = link;
    exp_q.push_back(e);
  endtask

  // Returns just after the clock edge on which the n-th handshake completes
  task automatic wait_pops(input int n);
    int i = 0;
    while (popped < n && i < 300) begin
      @(posedge clk);
      i++;
    end
    #1;
    check($sformatf("handshake_count_%0d", n), popped, n);
  endtask

  task automatic wait_valid();
    int i = 0;
    @(negedge clk);
    while (!instr_valid && i < 100) begin
      @(negedge clk);
      i++;
    end
    check("wait_instr_valid", {31'b0, instr_valid}, 1);
  endtask

  // Instruction memory: word at address a is 0xC0DE0000 | a, ack after lat cycles
  always @(negedge clk) begin
    if (!rst || !imem_req) begin
      imem_ack = 1'b0;
      cnt      = 0;
    end else if (cnt >= lat) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hC0DE_0000 | {17'b0, imem_addr};
      cnt        = 0;
    end else begin
      imem_ack = 1'b0;
      cnt++;
    end
  end

  always @(negedge clk) begin
    if (!rst || !w_imem_req) begin
      w_imem_ack = 1'b0;
      w_cnt      = 0;
    end else if (w_cnt >= 1) begin
      w_imem_ack   = 1'b1;
      w_imem_rdata = 32'hC0DE_0000 | {17'b0, w_imem_addr};
      w_cnt        = 0;
    end else begin
      w_imem_ack = 1'b0;
      w_cnt++;
    end
  end

  // Monitor: a handshake fires on the next edge when valid & ready and no redirect
  always @(negedge clk) begin
    exp_t e;
    if (rst && instr_valid && instr_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got instr_pc 0x%0h, expected no instruction", instr_pc);
      end else begin
        e = exp_q.pop_front();
        check("sb_instr_pc", {17'b0, instr_pc}, {17'b0, e.pc});
        check("sb_link_addr", {17'b0, link_addr}, {17'b0, e.link});
        check("sb_instr_out", instr_out, 32'hC0DE_0000 | {17'b0, e.pc});
      end
      popped++;
    end
  end

  // RESET_PC at the top of the address space
  initial begin
    w_done        = 1'b0;
    w_instr_ready = 1'b1;
    @(posedge rst);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (w_instr_valid) break;
    end
    check("wrap_valid", {31'b0, w_instr_valid}, 1);
    check("wrap_instr_pc", {17'b0, w_instr_pc}, 32'h7FFF);
    check("wrap_link_addr", {17'b0, w_link_addr}, 32'h0);
    check("wrap_instr_out", w_instr_out, 32'hC0DE_7FFF);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (w_imem_req) break;
    end
    check("wrap_next_req", {31'b0, w_imem_req}, 1);
    check("wrap_next_addr", {17'b0, w_imem_addr}, 32'h0);
    w_done = 1'b1;
  end

  initial begin
    rst             = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    instr_ready     = 1'b1;
    lat             = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_req", {31'b0, imem_req}, 0);
    check("rst_instr_valid", {31'b0, instr_valid}, 0);
    check("rst_instr_out", instr_out, 0);
    check("rst_instr_pc", {17'b0, instr_pc}, 0);
    check("rst_imem_addr", {17'b0, imem_addr}, 0);
    check("rst_w_imem_addr", {17'b0, w_imem_addr}, 32'h7FFF);

    push(15'h0, 15'h1);
    push(15'h1, 15'h2);
    push(15'h2, 15'h3);
    rst = 1'b1;
    @(negedge clk);
    check("idle_instr_valid", {31'b0, instr_valid}, 0);
    check("idle_imem_req", {31'b0, imem_req}, 0);
    wait_pops(3);

    // Decode stall
    instr_ready = 1'b0;
    push(15'h3, 15'h4);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("stall_instr_pc", {17'b0, instr_pc}, 32'h3);
      check("stall_instr_out", instr_out, 32'hC0DE_0003);
      check("stall_imem_req", {31'b0, imem_req}, 0);
      check("stall_link_addr", {17'b0, link_addr}, 32'h4);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    lat         = 3;
    instr_ready = 1'b1;
    wait_pops(4);

    // Redirect to 0x100 while the read of word 4 is outstanding
    @(negedge clk);
    check("req4_imem_req", {31'b0, imem_req}, 1);
    check("req4_imem_addr", {17'b0, imem_addr}, 32'h4);
    @(posedge clk);
    #1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0100;
    push(15'h100, 15'h101);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("hold_imem_req", {31'b0, imem_req}, 1);
    check("hold_imem_addr", {17'b0, imem_addr}, 32'h4);
    @(negedge clk);
    check("hold2_imem_addr", {17'b0, imem_addr}, 32'h4);
    wait_pops(5);

    // Redirect to 7 kills in-flight 0x101, then redirect in OUT with ready high
    instr_ready     = 1'b0;
    lat             = 1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0007;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    wait_valid();
    check("out7_instr_pc", {17'b0, instr_pc}, 32'h7);
    check("out7_link_addr", {17'b0, link_addr}, 32'h8);
    check("out7_instr_out", instr_out, 32'hC0DE_0007);
    @(posedge clk);
    #1;
    instr_ready     = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_0020;
    push(15'h20, 15'h21);
    push(15'h21, 15'h22);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    check("kill_instr_valid", {31'b0, instr_valid}, 0);
    check("kill_imem_req", {31'b0, imem_req}, 1);
    check("kill_imem_addr", {17'b0, imem_addr}, 32'h20);
    wait_pops(7);
    instr_ready = 1'b0;

`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, 7);
    check("perf_discarded", perf_discarded, 3);
`endif

    // Asynchronous reset in the middle of a request
    check("midrst_pre_req", {31'b0, imem_req}, 1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_imem_req", {31'b0, imem_req}, 0);
    check("midrst_instr_valid", {31'b0, instr_valid}, 0);
    check("midrst_imem_addr", {17'b0, imem_addr}, 32'h0);
`ifdef FETCH_PERF_EN
    check("midrst_perf_fetched", perf_fetched, 0);
    check("midrst_perf_discarded", perf_discarded, 0);
`endif
    @(posedge clk);
    #1;
    push(15'h0, 15'h1);
    push(15'h1, 15'h2);
    instr_ready = 1'b1;
    rst         = 1'b1;
    @(negedge clk);
    check("restart_idle_valid", {31'b0, instr_valid}, 0);
    check("restart_idle_req", {31'b0, imem_req}, 0);
    wait_pops(9);
    instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", exp_q.size(), 0);
    check("wrap_done", {31'b0, w_done}, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and instruction-fetch sequencer that consumes the branch controller's absolute target. It holds the PC, issues request/acknowledge reads to instruction memory, and presents one instruction at a time to decode over a valid/ready handshake. On a redirect it discards any in-flight fetch. It exports the link address that CALL pushes onto the return stack.

Parameters:
DWIDTH, 32, instruction/data width; also the width of redirect_target
AWIDTH, 15, instruction memory address width; PC width
RESET_PC, 0, PC value loaded on reset (AWIDTH bits)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
redirect_valid  input  1  one-cycle pulse: take branch/jump/ret to redirect_target
redirect_target  input  DWIDTH  absolute target; only low AWIDTH bits are used
imem_req  output  1  fetch request to instruction memory
imem_addr  output  AWIDTH  fetch address; stable while imem_req=1 and imem_ack=0
imem_ack  input  1  memory completed the read; imem_rdata valid this cycle
imem_rdata  input  DWIDTH  fetched instruction word
instr_out  output  DWIDTH  instruction presented to decode
instr_valid  output  1  instr_out/instr_pc are valid
instr_ready  input  1  decode accepts instr_out when instr_valid=1
instr_pc  output  AWIDTH  address of instr_out
link_addr  output  AWIDTH  instr_pc+1 mod 2^AWIDTH; branch_addr source for CALL

Behaviour:
- Reset (rst=0, asynchronous) puts the block in this state:
  - state=IDLE, pc=RESET_PC, req_addr=RESET_PC, discard=0
  - imem_req=0, instr_valid=0, instr_out=0, instr_pc=0
- States: IDLE, REQ, OUT.
- IDLE:
  - Outputs are idle.
  - Next cycle: req_addr<=pc, go to REQ. This gives one idle cycle after reset deassertion.
- REQ:
  - imem_req=1, imem_addr=req_addr.
  - On imem_ack with discard=0:
    - instr_out<=imem_rdata, instr_pc<=req_addr, instr_valid<=1
    - pc<=req_addr+1, wrapping mod 2^AWIDTH
    - go to OUT
  - On imem_ack with discard=1: drop the data, clear discard, req_addr<=pc, stay in REQ. The new request is issued the next cycle.
- OUT:
  - instr_valid=1; no memory request.
  - On instr_valid & instr_ready: instr_valid<=0, req_addr<=pc, go to REQ. Best-case throughput is one instruction per two cycles plus memory latency.
- Redirect has the highest priority. It always sets pc<=redirect_target[AWIDTH-1:0], and then depends on state:
  - IDLE: the target is used as the first fetch address.
  - REQ without ack: discard<=1. imem_addr stays at the old req_addr until the ack arrives, then that data is dropped as above.
  - REQ with ack in the same cycle: the data is dropped, req_addr<=target, stay in REQ.
  - OUT: instr_valid<=0 even if instr_ready=1 that cycle (the consumer's handshake is ignored), req_addr<=target, go to REQ.
- A redirect arriving while discard=1 only updates pc; a single drop is still enough.
- Wrap: pc=2^AWIDTH-1 increments to 0. link_addr wraps the same way.
- A redirect_target above 2^AWIDTH-1 is silently truncated.
- Mid-transaction reset: all state clears immediately. Memory must tolerate imem_req dropping without an ack.

Optional Feature:
FETCH_PERF_EN defined:
- Two 32-bit saturating counters, exposed on extra outputs perf_fetched and perf_discarded.
- perf_fetched increments on each instruction accepted by decode.
- perf_discarded increments on each dropped ack and each redirect in OUT that kills instr_valid.
- Both counters reset to 0.

FETCH_PERF_EN undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg:
  - fetch state encoding (IDLE/REQ/OUT)
  - opcode constants shared with the branch controller (JR, JPC, BRFL, CALL, RET)
  - default widths
- Sub-module fetch_perf_counter: saturating counter, instantiated twice, only under FETCH_PERF_EN.
- Everything else stays in one module.

Test Plan:
- Reset release with RESET_PC=0 and memory acking 1 cycle after req: fetches at 0,1,2 in order. instr_pc 0,1,2; link_addr 1,2,3; instr_valid low during reset and the first cycle after.
- Decode holds instr_ready=0 for 5 cycles in OUT: instr_out/instr_pc stable, imem_req=0, no PC advance.
- Redirect to 0x100 while in REQ at addr 4 with ack 3 cycles late:
  - imem_addr stays 4 until the ack; word 4 is never presented.
  - The next request is 0x100 and instr_pc=0x100.
- Redirect to 0x20 in OUT while instr_ready=1 at pc 7: no handshake completes, instr_valid drops, next fetch is 0x20.
- RESET_PC=0x7FFF: first instr_pc=0x7FFF with link_addr=0; the next fetch address is 0.
- Assert rst mid-REQ: imem_req and instr_valid go 0 asynchronously; after release, fetch restarts at RESET_PC. With FETCH_PERF_EN, the counters read 0.
